density_probe_arbiter: RTL and testbench

Shares the single density probe engine (the PLL-lock/sync probe controller) among four requesters: drive profile detector, density capability analyzer, host diagnostic command, and auto-rate recovery. It selects one requester round-robin, issues a probe start pulse at that requester's rate, and routes completion and success back to the winner. It also enforces a guard gap between probes so the DPLL re-settles after a rate change, and aborts hung or cancelled probes with a watchdog.

---
 rtl/density_probe_arbiter_if.sv | 35 +++
 rtl/density_probe_arbiter.sv | 162 ++++++++++++++++
 tb/tb_density_probe_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/density_probe_arbiter_if.sv
// density_probe_arbiter_if: request/grant bus between the four probe
// requesters, the arbiter and the density probe engine.
//   req, req_rate           requester levels and per-requester rate codes
//   grant, done             one-hot owner and one-cycle completion pulse
//   result_success/timeout  outcome of the last finished probe
//   busy                    arbiter is not idle
//   probe_start/rate/enable commands to the probe engine
//   probe_complete/success  probe engine result
// slave modport: the arbiter. master modport: requesters and probe engine.
interface density_probe_arbiter_if;
    logic [3:0] req;
    logic [7:0] req_rate;
    logic [3:0] grant;
    logic [3:0] done;
    logic       result_success;
    logic       result_timeout;
    logic       busy;
    logic       probe_start;
    logic [1:0] probe_rate;
    logic       probe_enable;
    logic       probe_complete;
    logic       probe_success;

    modport slave (
        input  req, req_rate, probe_complete, probe_success,
        output grant, done, result_success, result_timeout, busy,
               probe_start, probe_rate, probe_enable
    );

    modport master (
        output req, req_rate, probe_complete, probe_success,
        input  grant, done, result_success, result_timeout, busy,
               probe_start, probe_rate, probe_enable
    );
endinterface

// File: rtl/density_probe_arbiter.sv
// density_probe_arbiter: shares one density probe engine among four
// requesters with round-robin selection, a post-probe guard gap so the DPLL
// re-settles, and a watchdog / cancel abort path.
//   clk     system clock
//   reset   synchronous, active-high
//   enable  block enable; low forces IDLE
//   bus     density_probe_arbiter_if.slave (requests, grant/done, results,
//           probe engine command and status)
// All outputs are registered.
module density_probe_arbiter #(
    parameter int GUARD_CYCLES    = 1024,
    parameter int WATCHDOG_CYCLES = 8000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    density_probe_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_ABORT} state_e;

    localparam int            GW         = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
    localparam logic [23:0]   WD_LAST    = 24'(WATCHDOG_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    done_q, done_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    probe_rate_q, probe_rate_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [23:0]   wd_q, wd_d;
    logic          result_success_q, result_success_d;
    logic          result_timeout_q, result_timeout_d;
    logic          busy_q, busy_d;
    logic          probe_start_q, probe_start_d;
    logic          probe_enable_q, probe_enable_d;

    logic          pick_vld;
    logic [1:0]    pick_idx;
    logic          owner_req;

    // Round-robin: first set request scanning from ptr+1 upward. The 2-bit
    // sum wraps mod 4, so the last owner is scanned last and loses to any
    // other pending requester.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_vld && bus.req[ptr_q + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + 2'(k);
            end
        end
    end

    assign owner_req = |(bus.req & grant_q);

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        done_d           = '0;
        ptr_d            = ptr_q;
        probe_rate_d     = probe_rate_q;
        guard_d          = guard_q;
        wd_d             = wd_q;
        result_success_d = result_success_q;
        result_timeout_d = result_timeout_q;
        probe_start_d    = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            grant_d = '0;
            guard_d = GUARD_LOAD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (guard_q != '0) begin
                        guard_d = guard_q - GW'(1);
                    end else if (pick_vld) begin
                        grant_d      = 4'b0001 << pick_idx;
                        ptr_d        = pick_idx;
                        probe_rate_d = bus.req_rate[{pick_idx, 1'b0} +: 2];
                        state_d      = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    probe_start_d = 1'b1;
                    wd_d          = '0;
                    state_d       = S_BUSY;
                end
                S_BUSY: begin
                    wd_d = wd_q + 24'd1;
                    // Completion beats cancel, which beats the watchdog.
                    if (bus.probe_complete) begin
                        result_success_d = bus.probe_success;
                        result_timeout_d = 1'b0;
                        done_d           = grant_q;
                        grant_d          = '0;
                        guard_d          = GUARD_LOAD;
                        state_d          = S_IDLE;
                    end else if (!owner_req) begin
                        state_d = S_ABORT;
                    end else if (wd_q == WD_LAST) begin
                        result_timeout_d = 1'b1;
                        result_success_d = 1'b0;
                        done_d           = grant_q;
                        state_d          = S_ABORT;
                    end
                end
                S_ABORT: begin
                    grant_d = '0;
                    guard_d = GUARD_LOAD;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
        // The abort pulse lands the cycle after ABORT, with the grant clear.
        probe_enable_d = enable && (state_q != S_ABORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            grant_q          <= '0;
            done_q           <= '0;
            ptr_q            <= 2'd3;
            probe_rate_q     <= 2'b10;
            guard_q          <= '0;
            wd_q             <= '0;
            result_success_q <= 1'b0;
            result_timeout_q <= 1'b0;
            busy_q           <= 1'b0;
            probe_start_q    <= 1'b0;
            probe_enable_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            done_q           <= done_d;
            ptr_q            <= ptr_d;
            probe_rate_q     <= probe_rate_d;
            guard_q          <= guard_d;
            wd_q             <= wd_d;
            result_success_q <= result_success_d;
            result_timeout_q <= result_timeout_d;
            busy_q           <= busy_d;
            probe_start_q    <= probe_start_d;
            probe_enable_q   <= probe_enable_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.done           = done_q;
    assign bus.result_success = result_success_q;
    assign bus.result_timeout = result_timeout_q;
    assign bus.busy           = busy_q;
    assign bus.probe_start    = probe_start_q;
    assign bus.probe_rate     = probe_rate_q;
    assign bus.probe_enable   = probe_enable_q;
endmodule

// File: tb/tb_density_probe_arbiter.sv
// Directed bench for density_probe_arbiter with GUARD_CYCLES=4 and
// WATCHDOG_CYCLES=100. Inputs change 1 time unit after each rising edge;
// outputs are read at the same point, so each tick() advances one cycle.
module tb_density_probe_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   checks = 0;
    int   errors = 0;
    int   n;

    density_probe_arbiter_if bus();

    density_probe_arbiter #(.GUARD_CYCLES(4), .WATCHDOG_CYCLES(100)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until probe_start is seen or the limit expires; n = ticks taken.
    task automatic wait_start(input int limit, output int cnt);
        cnt = 0;
        while (bus.probe_start !== 1'b1 && cnt < limit) begin
            tick();
            cnt++;
        end
        chk("start_seen", 32'(bus.probe_start), 32'd1);
    endtask

    initial begin
        reset              = 1'b1;
        enable             = 1'b0;
        bus.req            = 4'b0000;
        bus.req_rate       = 8'b01_11_10_00;  // r3=01 r2=11 r1=10 r0=00
        bus.probe_complete = 1'b0;
        bus.probe_success  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_succ", 32'(bus.result_success), 32'd0);
        chk("rst_tmo", 32'(bus.result_timeout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.probe_start), 32'd0);
        chk("rst_rate", 32'(bus.probe_rate), 32'd2);
        chk("rst_pen", 32'(bus.probe_enable), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("pen_follow", 32'(bus.probe_enable), 32'd1);

        // Single requester 1, completion 10 cycles after start
        bus.req = 4'b0010;
        tick();
        chk("t1_grant", 32'(bus.grant), 32'h2);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_nostart", 32'(bus.probe_start), 32'd0);
        tick();
        chk("t1_start", 32'(bus.probe_start), 32'd1);
        chk("t1_rate", 32'(bus.probe_rate), 32'd2);
        tick();
        chk("t1_start_pulse", 32'(bus.probe_start), 32'd0);
        repeat (9) tick();
        bus.probe_complete = 1'b1;
        bus.probe_success  = 1'b1;
        tick();
        chk("t1_done", 32'(bus.done), 32'h2);
        chk("t1_succ", 32'(bus.result_success), 32'd1);
        chk("t1_tmo", 32'(bus.result_timeout), 32'd0);
        chk("t1_grant_clr", 32'(bus.grant), 32'd0);
        chk("t1_busy_clr", 32'(bus.busy), 32'd0);
        bus.probe_complete = 1'b0;
        bus.req            = 4'b0000;
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        // Stray completion while idle is ignored
        bus.probe_complete = 1'b1;
        bus.probe_success  = 1'b0;
        tick();
        bus.probe_complete = 1'b0;
        tick();
        chk("stray_done", 32'(bus.done), 32'd0);
        chk("stray_succ", 32'(bus.result_success), 32'd1);

        // Fresh reset, then round-robin with all four requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_succ", 32'(bus.result_success), 32'd0);
        chk("rst2_grant", 32'(bus.grant), 32'd0);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(20, n);
            chk($sformatf("rr%0d_gap", i), 32'(n), (i == 0) ? 32'd2 : 32'd6);
            chk($sformatf("rr%0d_grant", i), 32'(bus.grant), 32'(4'b0001 << (i % 4)));
            tick();
            bus.probe_complete = 1'b1;
            bus.probe_success  = (i % 2 == 0);
            tick();
            chk($sformatf("rr%0d_done", i), 32'(bus.done), 32'(4'b0001 << (i % 4)));
            chk($sformatf("rr%0d_succ", i), 32'(bus.result_success), (i % 2 == 0) ? 32'd1 : 32'd0);
            bus.probe_complete = 1'b0;
        end
        bus.req = 4'b0000;

        // Watchdog: requester 2, engine never completes
        bus.req = 4'b0100;
        wait_start(30, n);
        chk("wd_rate", 32'(bus.probe_rate), 32'd3);
        repeat (99) tick();
        chk("wd_early_done", 32'(bus.done), 32'd0);
        tick();
        chk("wd_done", 32'(bus.done), 32'h4);
        chk("wd_tmo", 32'(bus.result_timeout), 32'd1);
        chk("wd_succ", 32'(bus.result_success), 32'd0);
        chk("wd_pen_hi", 32'(bus.probe_enable), 32'd1);
        tick();
        chk("wd_pen_lo", 32'(bus.probe_enable), 32'd0);
        chk("wd_grant_clr", 32'(bus.grant), 32'd0);
        chk("wd_done_pulse", 32'(bus.done), 32'd0);
        bus.req = 4'b0000;
        tick();
        chk("wd_pen_back", 32'(bus.probe_enable), 32'd1);

        // Cancel: requesters 1 and 3 pending, 3 wins then drops
        bus.req = 4'b1010;
        wait_start(30, n);
        chk("cx_grant", 32'(bus.grant), 32'h8);
        chk("cx_rate", 32'(bus.probe_rate), 32'd1);
        tick();
        bus.req = 4'b0010;
        tick();
        chk("cx_grant_hold", 32'(bus.grant), 32'h8);
        chk("cx_nodone1", 32'(bus.done), 32'd0);
        tick();
        chk("cx_pen_lo", 32'(bus.probe_enable), 32'd0);
        chk("cx_grant_clr", 32'(bus.grant), 32'd0);
        chk("cx_nodone2", 32'(bus.done), 32'd0);
        wait_start(20, n);
        chk("cx_gap", 32'(n), 32'd6);
        chk("cx_next_grant", 32'(bus.grant), 32'h2);
        chk("cx_next_rate", 32'(bus.probe_rate), 32'd2);
        tick();
        bus.probe_complete = 1'b1;
        bus.probe_success  = 1'b0;
        tick();
        chk("cx_done", 32'(bus.done), 32'h2);
        chk("cx_succ", 32'(bus.result_success), 32'd0);
        chk("cx_tmo_clr", 32'(bus.result_timeout), 32'd0);
        bus.probe_complete = 1'b0;
        bus.req            = 4'b0000;

        // Completion, cancel and watchdog expiry in one cycle
        bus.req = 4'b0001;
        wait_start(30, n);
        chk("sim_grant", 32'(bus.grant), 32'h1);
        bus.req_rate = 8'b01_11_10_11;
        repeat (99) tick();
        chk("sim_rate_hold", 32'(bus.probe_rate), 32'd0);
        chk("sim_nodone", 32'(bus.done), 32'd0);
        bus.probe_complete = 1'b1;
        bus.probe_success  = 1'b1;
        bus.req            = 4'b0000;
        tick();
        bus.probe_complete = 1'b0;
        bus.req_rate       = 8'b01_11_10_00;
        chk("sim_done", 32'(bus.done), 32'h1);
        chk("sim_succ", 32'(bus.result_success), 32'd1);
        chk("sim_tmo", 32'(bus.result_timeout), 32'd0);
        tick();
        chk("sim_no_abort", 32'(bus.probe_enable), 32'd1);
        chk("sim_busy", 32'(bus.busy), 32'd0);

        // enable low for 3 cycles mid-BUSY
        bus.req = 4'b0100;
        wait_start(30, n);
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("en_grant", 32'(bus.grant), 32'd0);
        chk("en_busy", 32'(bus.busy), 32'd0);
        chk("en_pen", 32'(bus.probe_enable), 32'd0);
        chk("en_nodone1", 32'(bus.done), 32'd0);
        tick();
        chk("en_nodone2", 32'(bus.done), 32'd0);
        tick();
        chk("en_nodone3", 32'(bus.done), 32'd0);
        enable = 1'b1;
        wait_start(20, n);
        chk("en_gap", 32'(n), 32'd6);
        chk("en_regrant", 32'(bus.grant), 32'h4);
        chk("en_succ_hold", 32'(bus.result_success), 32'd1);
        tick();
        bus.probe_complete = 1'b1;
        bus.probe_success  = 1'b0;
        tick();
        chk("en_done", 32'(bus.done), 32'h4);
        chk("en_succ", 32'(bus.result_success), 32'd0);
        bus.probe_complete = 1'b0;
        bus.req            = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
